// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two read ports, two write-back ports,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb0_en,
    input  logic [AW-1:0]   wb0_addr,
    input  logic [XLEN-1:0] wb0_data,
    input  logic            wb1_en,
    input  logic [AW-1:0]   wb1_addr,
    input  logic [XLEN-1:0] wb1_data
);
    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] rview [NREG];
    logic [NREG-1:0] busy;
    logic            m01, m11, m02, m12;

    assign rview[0] = '0;
    assign busy[0]  = 1'b0;

    // Per-register storage; wb0 has priority over wb1, issue set over write-back clear.
    for (genvar i = 1; i < NREG; i++) begin : g_reg
        logic [XLEN-1:0] r;
        logic            b;
        logic            hit0, hit1, set;
        assign hit0 = wb0_en && wb0_addr == AW'(i);
        assign hit1 = wb1_en && wb1_addr == AW'(i);
        assign set  = issue_en && issue_rd == AW'(i);
        always_ff @(posedge clk)
            if (!rst) begin
                r <= '0;
                b <= 1'b0;
            end else begin
                r <= hit0 ? wb0_data : hit1 ? wb1_data : r;
                b <= set || (b && !(hit0 || hit1));
            end
        assign rview[i] = r;
        assign busy[i]  = b;
    end

    always_comb begin
        m01 = wb0_en && wb0_addr == rs1_addr;
        m11 = wb1_en && wb1_addr == rs1_addr;
        m02 = wb0_en && wb0_addr == rs2_addr;
        m12 = wb1_en && wb1_addr == rs2_addr;
        rs1_data = (!rst || rs1_addr == '0) ? '0 : m01 ? wb0_data : m11 ? wb1_data : rview[rs1_addr];
        rs2_data = (!rst || rs2_addr == '0) ? '0 : m02 ? wb0_data : m12 ? wb1_data : rview[rs2_addr];
        rs1_busy = rst && busy[rs1_addr] && !(m01 || m11);
        rs2_busy = rst && busy[rs2_addr] && !(m02 || m12);
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: vector table plus model-driven random cycles for regfile_sb,
// with a 64-bit / AW=4 instance for the parameter sweep.
module tb_regfile_sb;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb0_addr, wb1_addr;
    logic        issue_en, wb0_en, wb1_en;
    logic [31:0] wb0_data, wb1_data, rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;

    logic [3:0]  p_a1, p_a2, p_ird, p_w0a, p_w1a;
    logic        p_ie, p_w0e, p_w1e, p_b1, p_b2;
    logic [63:0] p_w0d, p_w1d, p_d1, p_d2;

    regfile_sb dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_en(issue_en), .issue_rd(issue_rd), .wb0_en(wb0_en), .wb0_addr(wb0_addr),
        .wb0_data(wb0_data), .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data)
    );

    regfile_sb #(.XLEN(64), .AW(4)) dut64 (
        .clk(clk), .rst(rst), .rs1_addr(p_a1), .rs2_addr(p_a2),
        .rs1_data(p_d1), .rs2_data(p_d2), .rs1_busy(p_b1), .rs2_busy(p_b2),
        .issue_en(p_ie), .issue_rd(p_ird), .wb0_en(p_w0e), .wb0_addr(p_w0a),
        .wb0_data(p_w0d), .wb1_en(p_w1e), .wb1_addr(p_w1a), .wb1_data(p_w1d)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic [4:0]  a1, a2;
        logic        ie;
        logic [4:0]  ird;
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic [31:0] e1;
        logic        b1;
        logic [31:0] e2;
        logic        b2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[23];
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [31:0] pre [32];
    int          n_pass = 0;
    int          n_tot = 0;

    // Reference state, updated from the driven inputs at each rising edge.
    always @(posedge clk)
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (wb1_en && wb1_addr != 0) m_regs[wb1_addr] <= wb1_data;
            if (wb0_en && wb0_addr != 0) m_regs[wb0_addr] <= wb0_data;
            if (wb0_en) m_busy[wb0_addr] <= 1'b0;
            if (wb1_en) m_busy[wb1_addr] <= 1'b0;
            if (issue_en) m_busy[issue_rd] <= 1'b1;
        end

    function automatic void mexp(input logic [4:0] a, output logic [31:0] d, output logic b);
        logic m0, m1;
        m0 = wb0_en && wb0_addr == a;
        m1 = wb1_en && wb1_addr == a;
        if (!rst || a == 0) begin
            d = '0;
            b = 1'b0;
        end else begin
            d = m0 ? wb0_data : m1 ? wb1_data : m_regs[a];
            b = m_busy[a] && !m0 && !m1;
        end
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    task automatic cycle(input vec_t v, input bit use_model);
        exp_t e;
        @(negedge clk);
        rst = v.rst; rs1_addr = v.a1; rs2_addr = v.a2;
        issue_en = v.ie; issue_rd = v.ird;
        wb0_en = v.w0e; wb0_addr = v.w0a; wb0_data = v.w0d;
        wb1_en = v.w1e; wb1_addr = v.w1a; wb1_data = v.w1d;
        e.name = v.name;
        if (use_model) begin
            mexp(v.a1, e.d1, e.b1);
            mexp(v.a2, e.d2, e.b2);
        end else begin
            e.d1 = v.e1; e.b1 = v.b1; e.d2 = v.e2; e.b2 = v.b2;
        end
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk({e.name, ".rs1_data"}, 64'(rs1_data), 64'(e.d1));
        chk({e.name, ".rs1_busy"}, 64'(rs1_busy), 64'(e.b1));
        chk({e.name, ".rs2_data"}, 64'(rs2_data), 64'(e.d2));
        chk({e.name, ".rs2_busy"}, 64'(rs2_busy), 64'(e.b2));
    endtask

    initial begin
        vec_t t;
        rst = 1'b0; rs1_addr = '0; rs2_addr = '0; issue_en = 1'b0; issue_rd = '0;
        wb0_en = 1'b0; wb0_addr = '0; wb0_data = '0; wb1_en = 1'b0; wb1_addr = '0; wb1_data = '0;
        p_a1 = '0; p_a2 = '0; p_ie = 1'b0; p_ird = '0; p_w0e = 1'b0; p_w0a = '0; p_w0d = '0;
        p_w1e = 1'b0; p_w1a = '0; p_w1d = '0;

        t = '{"rst_hold", 0, 1, 2, 0, 0, 1, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0};
        cycle(t, 0);
        cycle(t, 0);
        for (int i = 1; i < 32; i++) begin
            pre[i] = $urandom;
            t = '{"preload", 1, 5'(i), 0, 0, 0, 1, 5'(i), pre[i], 0, 0, 0, pre[i], 0, 0, 0};
            cycle(t, 0);
        end
        t = '{"pre_issue", 1, 10, 31, 1, 10, 0, 0, 0, 0, 0, 0, pre[10], 0, pre[31], 0};
        cycle(t, 0);
        t = '{"busy_pre", 1, 10, 31, 0, 0, 0, 0, 0, 0, 0, 0, pre[10], 1, pre[31], 0};
        cycle(t, 0);
        t = '{"rst_pulse", 0, 31, 10, 1, 11, 1, 31, 32'hFFFFFFFF, 1, 10, 32'h1, 0, 0, 0, 0};
        cycle(t, 0);
        for (int i = 0; i < 32; i++) begin
            t = '{"rst_read", 1, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            cycle(t, 0);
        end

        vt[0]  = '{"bypass_pri", 1, 5, 5, 0, 0, 1, 5, 32'h11111111, 1, 5, 32'h22222222, 32'h11111111, 0, 32'h11111111, 0};
        vt[1]  = '{"pri_array", 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111, 0, 0, 0};
        vt[2]  = '{"wb1_only", 1, 6, 5, 0, 0, 0, 0, 0, 1, 6, 32'h22222222, 32'h22222222, 0, 32'h11111111, 0};
        vt[3]  = '{"wb1_array", 1, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 32'h22222222, 0, 32'h22222222, 0};
        vt[4]  = '{"x0_write", 1, 0, 0, 1, 0, 1, 0, 32'hDEADBEEF, 1, 0, 32'h12345678, 0, 0, 0, 0};
        vt[5]  = '{"x0_later", 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h11111111, 0};
        vt[6]  = '{"issue7", 1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[7]  = '{"busy7", 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        vt[8]  = '{"busy7_hold", 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[9]  = '{"busy7_hold2", 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[10] = '{"wb1_x7", 1, 7, 7, 0, 0, 0, 0, 0, 1, 7, 32'hCAFEF00D, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0};
        vt[11] = '{"after7", 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0};
        vt[12] = '{"setclr9", 1, 9, 9, 1, 9, 0, 0, 0, 1, 9, 32'h5, 32'h5, 0, 32'h5, 0};
        vt[13] = '{"after9", 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5, 1, 0, 0};
        vt[14] = '{"wb0_clr9", 1, 9, 9, 0, 0, 1, 9, 32'hA, 0, 0, 0, 32'hA, 0, 32'hA, 0};
        vt[15] = '{"after9b", 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA, 0, 0, 0};
        vt[16] = '{"issue3", 1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[17] = '{"reissue3", 1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        vt[18] = '{"wb0_x3", 1, 3, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 32'h33, 0, 0, 0};
        vt[19] = '{"issue8", 1, 3, 8, 1, 8, 0, 0, 0, 0, 0, 0, 32'h33, 0, 0, 0};
        vt[20] = '{"rst_mid", 0, 8, 4, 1, 4, 1, 4, 32'h44, 1, 8, 32'h88, 0, 0, 0, 0};
        vt[21] = '{"post_rst", 1, 8, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[22] = '{"post_rst_x3", 1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 23; i++) cycle(vt[i], 0);

        for (int i = 0; i < 300; i++) begin
            t.name = "rand";
            t.rst = 1'($urandom_range(0, 19) != 0);
            t.a1 = 5'($urandom_range(0, 7));
            t.a2 = 5'($urandom_range(0, 7));
            t.ie = 1'($urandom_range(0, 1));
            t.ird = 5'($urandom_range(0, 7));
            t.w0e = 1'($urandom_range(0, 1));
            t.w0a = 5'($urandom_range(0, 7));
            t.w0d = $urandom;
            t.w1e = 1'($urandom_range(0, 1));
            t.w1a = 5'($urandom_range(0, 7));
            t.w1d = $urandom;
            cycle(t, 1);
        end

        @(negedge clk);
        rst = 1'b1; issue_en = 1'b0; wb0_en = 1'b0; wb1_en = 1'b0;
        p_w0e = 1'b1; p_w0a = 4'd15; p_w0d = 64'hFFFF_FFFF_0000_0001; p_a1 = 4'd15; p_a2 = 4'd0;
        #2;
        chk("p64_bypass", p_d1, 64'hFFFF_FFFF_0000_0001);
        chk("p64_x0", p_d2, 64'h0);
        @(negedge clk);
        p_w0a = 4'd0; p_w0d = 64'h1234;
        #2;
        chk("p64_array", p_d1, 64'hFFFF_FFFF_0000_0001);
        chk("p64_x0_wr", p_d2, 64'h0);
        chk("p64_busy", 64'({p_b1, p_b2}), 64'h0);
        @(negedge clk);
        p_w0e = 1'b0;
        #2;
        chk("p64_x0_after", p_d2, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
